// File: rtl/ieee488_pkg.sv
// Shared types and constants for the IEEE-488 handshake engine.
// Bus lines are active-low throughout: REL (1) means released.
package ieee488_pkg;

    typedef enum logic [2:0] {
        AhOff,
        AhNrdy,
        AhRdy,
        AhAcpt,
        AhWait
    } ah_state_t;

    typedef enum logic [1:0] {
        ShIdle,
        ShSettle,
        ShDav,
        ShRel
    } sh_state_t;

    typedef struct packed {
        logic       atn;
        logic       eoi;
        logic [7:0] data;
    } rx_entry_t;

    typedef struct packed {
        logic       eoi;
        logic [7:0] data;
    } tx_entry_t;

    localparam logic REL = 1'b1;

endpackage

// File: rtl/ieee488_fifo.sv
// Synchronous FIFO with clock enable and occupancy output.
// Push when full and pop when empty are dropped silently.
module ieee488_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned LW   = AW + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ce,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [LW-1:0] cnt_q;
    logic          do_push, do_pop;

    assign full    = (cnt_q == LW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign level   = cnt_q;
    assign rdata   = mem[rd_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (ce) begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage needs no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (ce && do_push) mem[wr_q] <= wdata;
    end

endmodule

// File: rtl/ieee488_hs_engine.sv
// IEEE-488 source/acceptor handshake engine with TX/RX FIFOs, ATN trap and source timeout.
// Sits between a VIA-style host interface and the wired-AND, active-low bus.
module ieee488_hs_engine
    import ieee488_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned SETTLE = 2,
    parameter int unsigned TMO_W  = 12,
    localparam int unsigned LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ce,
    input  logic          talk_en,
    input  logic          listen_en,
    input  logic [7:0]    ieee_data_i,
    input  logic          ieee_atn_i,
    input  logic          ieee_dav_i,
    input  logic          ieee_eoi_i,
    input  logic          ieee_nrfd_i,
    input  logic          ieee_ndac_i,
    output logic [7:0]    ieee_data_o,
    output logic          ieee_dav_o,
    output logic          ieee_eoi_o,
    output logic          ieee_nrfd_o,
    output logic          ieee_ndac_o,
    input  logic          tx_wr,
    input  logic [7:0]    tx_data,
    input  logic          tx_eoi,
    output logic          tx_full,
    output logic [LW-1:0] tx_level,
    input  logic          rx_rd,
    output logic [7:0]    rx_data,
    output logic          rx_eoi,
    output logic          rx_atn,
    output logic          rx_empty,
    output logic          sh_timeout,
    output logic          no_listener
);

    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    logic atn_active, sh_en, ah_en;

    assign atn_active = ~ieee_atn_i;
    assign sh_en      = talk_en & ~atn_active;
    // Talker owns the bus outside ATN, so the acceptor stays off then.
    assign ah_en      = atn_active | (listen_en & ~talk_en);

    // FIFOs
    tx_entry_t       tx_wdata, tx_head;
    logic            tx_empty, tx_pop;
    rx_entry_t       rx_lat_q, rx_head;
    logic            rx_full, rx_push;
    logic [LW-1:0]   rx_lvl;

    assign tx_wdata = '{eoi: tx_eoi, data: tx_data};

    ieee488_fifo #(
        .W     (9),
        .DEPTH (DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .ce      (ce),
        .push    (tx_wr),
        .wdata   (tx_wdata),
        .pop     (tx_pop),
        .rdata   (tx_head),
        .full    (tx_full),
        .empty   (tx_empty),
        .level   (tx_level)
    );

    ieee488_fifo #(
        .W     (10),
        .DEPTH (DEPTH)
    ) u_rx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .ce      (ce),
        .push    (rx_push),
        .wdata   (rx_lat_q),
        .pop     (rx_rd),
        .rdata   (rx_head),
        .full    (rx_full),
        .empty   (rx_empty),
        .level   (rx_lvl)
    );

    assign rx_data = rx_head.data;
    assign rx_eoi  = rx_head.eoi;
    assign rx_atn  = rx_head.atn;

    // Acceptor handshake
    ah_state_t ah_q, ah_d;
    logic      ah_latch, rx_room, ah_nrfd, ah_ndac;

    // Keep a spare slot outside ATN so a command byte can always be taken.
    assign rx_room  = atn_active ? ~rx_full : (rx_lvl <= LW'(DEPTH - 2));
    assign ah_latch = (ah_q == AhRdy) & ah_en & ~ieee_dav_i;
    assign rx_push  = (ah_q == AhAcpt);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ah_q     <= AhOff;
            rx_lat_q <= '0;
        end else if (ce) begin
            ah_q <= ah_d;
            if (ah_latch) begin
                rx_lat_q <= '{atn: atn_active, eoi: ~ieee_eoi_i, data: ~ieee_data_i};
            end
        end
    end

    always_comb begin
        ah_d = ah_q;
        unique case (ah_q)
            AhOff:  if (ah_en) ah_d = AhNrdy;
            AhNrdy: begin
                if (!ah_en)       ah_d = AhOff;
                else if (rx_room) ah_d = AhRdy;
            end
            AhRdy: begin
                if (!ah_en)           ah_d = AhOff;
                else if (!ieee_dav_i) ah_d = AhAcpt;
            end
            AhAcpt: ah_d = AhWait;
            AhWait: if (ieee_dav_i) ah_d = AhNrdy;
            default: ah_d = AhOff;
        endcase
    end

    always_comb begin
        ah_nrfd = REL;
        ah_ndac = REL;
        unique case (ah_q)
            AhNrdy: begin ah_nrfd = 1'b0; ah_ndac = 1'b0; end
            AhRdy:  begin ah_nrfd = REL;  ah_ndac = 1'b0; end
            AhAcpt: begin ah_nrfd = 1'b0; ah_ndac = 1'b0; end
            AhWait: begin ah_nrfd = 1'b0; ah_ndac = REL;  end
            default: begin ah_nrfd = REL; ah_ndac = REL;  end
        endcase
    end

    // Source handshake
    sh_state_t        sh_q, sh_d;
    logic [3:0]       settle_q, settle_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             no_lst_q, no_lst_d, tmo_flag_q, tmo_flag_d;
    logic             settled, tmo_fire, sh_timing;
    logic [7:0]       sh_data;
    logic             sh_dav, sh_eoi;

    assign settled   = (settle_q == 4'(SETTLE));
    assign sh_timing = (sh_q == ShSettle) | (sh_q == ShDav);
    // Fires on the tick that brings the counter to all-ones.
    assign tmo_fire  = sh_timing & (tmo_q == TMO_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh_q       <= ShIdle;
            settle_q   <= '0;
            tmo_q      <= '0;
            no_lst_q   <= 1'b0;
            tmo_flag_q <= 1'b0;
        end else if (ce) begin
            sh_q       <= sh_d;
            settle_q   <= settle_d;
            tmo_q      <= tmo_d;
            no_lst_q   <= no_lst_d;
            tmo_flag_q <= tmo_flag_d;
        end
    end

    always_comb begin
        sh_d       = sh_q;
        settle_d   = settle_q;
        no_lst_d   = no_lst_q;
        tmo_flag_d = tmo_flag_q;
        tx_pop     = 1'b0;
        if (!sh_en) begin
            sh_d = ShIdle;
        end else begin
            unique case (sh_q)
                ShIdle: begin
                    settle_d = '0;
                    // A sticky fault parks the source until the host drops talk_en.
                    if (!tx_empty && !no_lst_q && !tmo_flag_q) sh_d = ShSettle;
                end
                ShSettle: begin
                    if (!settled) begin
                        settle_d = settle_q + 4'd1;
                    end else if (ieee_nrfd_i && ieee_ndac_i) begin
                        no_lst_d = 1'b1;
                        sh_d     = ShIdle;
                    end else if (ieee_nrfd_i && !ieee_ndac_i) begin
                        sh_d = ShDav;
                    end
                end
                ShDav: begin
                    if (ieee_ndac_i) begin
                        tx_pop = 1'b1;
                        sh_d   = ShRel;
                    end
                end
                ShRel:   sh_d = ShIdle;
                default: sh_d = ShIdle;
            endcase
            if (tmo_fire && (sh_d == sh_q)) begin
                sh_d       = ShIdle;
                tmo_flag_d = 1'b1;
            end
        end
        tmo_d = (sh_timing && (sh_d == sh_q)) ? tmo_q + 1'b1 : '0;
        if (!talk_en) begin
            no_lst_d   = 1'b0;
            tmo_flag_d = 1'b0;
        end
    end

    // Gated by atn_active directly so the release is combinational.
    always_comb begin
        sh_data = 8'hFF;
        sh_dav  = REL;
        sh_eoi  = REL;
        if (sh_en) begin
            unique case (sh_q)
                ShSettle: begin
                    sh_data = ~tx_head.data;
                    sh_eoi  = ~tx_head.eoi;
                end
                ShDav: begin
                    sh_data = ~tx_head.data;
                    sh_eoi  = ~tx_head.eoi;
                    sh_dav  = 1'b0;
                end
                default: begin
                    sh_data = 8'hFF;
                    sh_dav  = REL;
                    sh_eoi  = REL;
                end
            endcase
        end
    end

    assign ieee_data_o = sh_data;
    assign ieee_dav_o  = sh_dav;
    assign ieee_eoi_o  = sh_eoi;
    assign ieee_nrfd_o = ah_nrfd;
    assign ieee_ndac_o = ah_ndac;
    assign sh_timeout  = tmo_flag_q;
    assign no_listener = no_lst_q;

endmodule

// File: tb/tb_ieee488_hs_engine.sv
// Directed bench for ieee488_hs_engine: the bench plays controller/talker/listener
// on a wired-AND bus model and checks received and sent bytes against scoreboards.
module tb_ieee488_hs_engine;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          ce = 1'b1;
    logic          talk_en = 1'b0, listen_en = 1'b0;
    logic          tx_wr = 1'b0, tx_eoi = 1'b0, rx_rd = 1'b0;
    logic [7:0]    tx_data = 8'h00;
    logic [7:0]    ieee_data_o;
    logic          ieee_dav_o, ieee_eoi_o, ieee_nrfd_o, ieee_ndac_o;
    logic          tx_full, rx_eoi, rx_atn, rx_empty, sh_timeout, no_listener;
    logic [LW-1:0] tx_level;
    logic [7:0]    rx_data;

    // Bench-side bus drivers, wired-AND with the DUT outputs
    logic [7:0] tb_data = 8'hFF;
    logic       tb_atn = 1'b1, tb_dav = 1'b1, tb_eoi = 1'b1, tb_nrfd = 1'b1, tb_ndac = 1'b1;
    logic [7:0] bus_data;
    logic       bus_dav, bus_eoi, bus_nrfd, bus_ndac;

    assign bus_data = ieee_data_o & tb_data;
    assign bus_dav  = ieee_dav_o & tb_dav;
    assign bus_eoi  = ieee_eoi_o & tb_eoi;
    assign bus_nrfd = ieee_nrfd_o & tb_nrfd;
    assign bus_ndac = ieee_ndac_o & tb_ndac;

    int checks = 0;
    int errors = 0;
    logic [9:0] rx_q[$];
    logic [8:0] tx_q[$];

    ieee488_hs_engine #(
        .DEPTH  (DEPTH),
        .SETTLE (2),
        .TMO_W  (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ce          (ce),
        .talk_en     (talk_en),
        .listen_en   (listen_en),
        .ieee_data_i (bus_data),
        .ieee_atn_i  (tb_atn),
        .ieee_dav_i  (bus_dav),
        .ieee_eoi_i  (bus_eoi),
        .ieee_nrfd_i (bus_nrfd),
        .ieee_ndac_i (bus_ndac),
        .ieee_data_o (ieee_data_o),
        .ieee_dav_o  (ieee_dav_o),
        .ieee_eoi_o  (ieee_eoi_o),
        .ieee_nrfd_o (ieee_nrfd_o),
        .ieee_ndac_o (ieee_ndac_o),
        .tx_wr       (tx_wr),
        .tx_data     (tx_data),
        .tx_eoi      (tx_eoi),
        .tx_full     (tx_full),
        .tx_level    (tx_level),
        .rx_rd       (rx_rd),
        .rx_data     (rx_data),
        .rx_eoi      (rx_eoi),
        .rx_atn      (rx_atn),
        .rx_empty    (rx_empty),
        .sh_timeout  (sh_timeout),
        .no_listener (no_listener)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        talk_en = 1'b0; listen_en = 1'b0; tx_wr = 1'b0; rx_rd = 1'b0;
        tb_data = 8'hFF; tb_atn = 1'b1; tb_dav = 1'b1; tb_eoi = 1'b1;
        tb_nrfd = 1'b1; tb_ndac = 1'b1;
        reset_n = 1'b0;
        rx_q.delete();
        tx_q.delete();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic chk_released(input string tag);
        chk({tag, "_data"}, ieee_data_o, 8'hFF);
        chk({tag, "_ctl"}, {ieee_dav_o, ieee_eoi_o, ieee_nrfd_o, ieee_ndac_o}, 4'hF);
        chk({tag, "_fifo"}, {tx_full, tx_level, rx_empty}, {1'b0, LW'(0), 1'b1});
    endtask

    task automatic push_tx(input logic [7:0] d, input logic e, input bit accept);
        tx_data = d; tx_eoi = e; tx_wr = 1'b1;
        if (accept) tx_q.push_back({e, d});
        tick();
        tx_wr = 1'b0;
    endtask

    // Controller/talker sending one byte to the DUT acceptor.
    task automatic send_byte(input logic [7:0] d, input logic e);
        int n = 0;
        tb_data = ~d; tb_eoi = ~e;
        while (bus_nrfd !== 1'b1 && n < 30) begin tick(); n++; end
        chk("snd_rfd", bus_nrfd, 1'b1);
        rx_q.push_back({~tb_atn, e, d});
        tick();
        tb_dav = 1'b0;
        tick();
        chk("snd_nrfd_low", ieee_nrfd_o, 1'b0);
        tick();
        chk("snd_ndac_high", ieee_ndac_o, 1'b1);
        tb_dav = 1'b1; tb_data = 8'hFF; tb_eoi = 1'b1;
        tick();
    endtask

    task automatic read_rx();
        logic [9:0] exp = 10'h0;
        chk("rx_nonempty", rx_empty, 1'b0);
        if (rx_q.size() != 0) exp = rx_q.pop_front();
        chk("rx_entry", {rx_atn, rx_eoi, rx_data}, exp);
        rx_rd = 1'b1;
        tick();
        rx_rd = 1'b0;
    endtask

    // Listener accepting one byte from the DUT source.
    task automatic listen_byte();
        int n = 0;
        logic [8:0] exp = 9'h0;
        tb_nrfd = 1'b1; tb_ndac = 1'b0;
        while (bus_dav !== 1'b0 && n < 40) begin tick(); n++; end
        chk("lst_dav", bus_dav, 1'b0);
        if (tx_q.size() != 0) exp = tx_q.pop_front();
        chk("lst_byte", {~bus_eoi, ~bus_data}, exp);
        tb_nrfd = 1'b0; tb_ndac = 1'b1;
        n = 0;
        while (bus_dav !== 1'b1 && n < 10) begin tick(); n++; end
        chk("lst_dav_rel", bus_dav, 1'b1);
        tb_ndac = 1'b0; tb_nrfd = 1'b1;
        tick();
    endtask

    initial begin
        int pre;
        int lows;
        int n;

        // Reset state
        do_reset();
        chk_released("rst");
        chk("rst_flags", {sh_timeout, no_listener}, 2'b00);

        // Listener, three bytes with EOI on the last
        listen_en = 1'b1;
        tick(); tick();
        send_byte(8'h41, 1'b0);
        send_byte(8'h42, 1'b0);
        send_byte(8'h43, 1'b1);
        read_rx(); read_rx(); read_rx();
        chk("lst_drained", rx_empty, 1'b1);

        // Talker to model listener
        do_reset();
        talk_en = 1'b1; tb_nrfd = 1'b1; tb_ndac = 1'b0;
        push_tx(8'hA5, 1'b1, 1'b1);
        chk("tk_level1", tx_level, LW'(1));
        pre = 0; n = 0;
        while (bus_dav !== 1'b0 && n < 40) begin
            if (ieee_data_o === 8'h5A && ieee_eoi_o === 1'b0) pre++;
            tick(); n++;
        end
        chk("tk_dav_fall", ieee_dav_o, 1'b0);
        chk("tk_settle", (pre >= 2), 1'b1);
        chk("tk_byte", {~ieee_eoi_o, ~ieee_data_o}, tx_q.pop_front());
        chk("tk_level_hold", tx_level, LW'(1));
        tb_ndac = 1'b1; tb_nrfd = 1'b0;
        tick();
        chk("tk_level0", tx_level, LW'(0));
        chk("tk_dav_rel", ieee_dav_o, 1'b1);
        tb_ndac = 1'b0; tb_nrfd = 1'b1;
        tick();

        // ATN command interrupts a pending source byte
        do_reset();
        talk_en = 1'b1; tb_nrfd = 1'b1; tb_ndac = 1'b0;
        push_tx(8'h55, 1'b0, 1'b1);
        n = 0;
        while (ieee_dav_o !== 1'b0 && n < 40) begin tick(); n++; end
        chk("atn_pre_dav", ieee_dav_o, 1'b0);
        tb_atn = 1'b0;
        #1;
        chk("atn_rel_data", ieee_data_o, 8'hFF);
        chk("atn_rel_ctl", {ieee_dav_o, ieee_eoi_o}, 2'b11);
        tb_ndac = 1'b1;
        tick(); tick();
        send_byte(8'h28, 1'b0);
        read_rx();
        chk("atn_level_kept", tx_level, LW'(1));
        tb_nrfd = 1'b1; tb_ndac = 1'b0; tb_atn = 1'b1;
        listen_byte();
        lows = 0;
        for (int i = 0; i < 30; i++) begin
            if (bus_dav === 1'b0) lows++;
            tick();
        end
        chk("atn_resend_once", lows, 0);
        chk("atn_level0", tx_level, LW'(0));

        // No listener present
        do_reset();
        talk_en = 1'b1; tb_nrfd = 1'b1; tb_ndac = 1'b1;
        push_tx(8'h01, 1'b0, 1'b1);
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            if (ieee_dav_o === 1'b0) lows++;
            tick();
        end
        chk("nl_dav_idle", lows, 0);
        chk("nl_flag", no_listener, 1'b1);
        chk("nl_level", tx_level, LW'(1));
        talk_en = 1'b0;
        tick();
        chk("nl_clear", no_listener, 1'b0);

        // Source timeout with a listener holding NRFD low
        do_reset();
        talk_en = 1'b1; tb_nrfd = 1'b0; tb_ndac = 1'b0;
        push_tx(8'h77, 1'b0, 1'b1);
        repeat (14) tick();
        chk("tmo_early", sh_timeout, 1'b0);
        repeat (2) tick();
        chk("tmo_fire", sh_timeout, 1'b1);
        chk("tmo_rel", {ieee_dav_o, ieee_data_o}, {1'b1, 8'hFF});
        chk("tmo_level", tx_level, LW'(1));
        talk_en = 1'b0;
        tick();
        chk("tmo_clear", sh_timeout, 1'b0);

        // RX full, TX full, then reset mid-byte
        do_reset();
        for (int i = 0; i < 5; i++) push_tx(8'h10 + 8'(i), 1'b0, i < DEPTH);
        chk("txf_full", tx_full, 1'b1);
        chk("txf_level", tx_level, LW'(DEPTH));
        listen_en = 1'b1;
        tick(); tick();
        send_byte(8'hB1, 1'b0);
        send_byte(8'hB2, 1'b0);
        send_byte(8'hB3, 1'b0);
        tb_data = ~8'hB4;
        repeat (20) tick();
        chk("rxf_nrfd_held", bus_nrfd, 1'b0);
        chk("rxf_nonempty", rx_empty, 1'b0);
        read_rx();
        tick();
        chk("rxf_ready_again", ieee_nrfd_o, 1'b1);
        tb_dav = 1'b0;
        tick();
        reset_n = 1'b0;
        #1;
        chk_released("rxf_rst");
        tb_dav = 1'b1; tb_data = 8'hFF;
        tick();
        reset_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
